// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
//   Shared types and constants for the four-decade BCD counter.
//     bcd_t        : one BCD digit (legal values 0..9)
//     BCD_MAX      : largest legal digit value
//     NUM_DIGITS   : number of decades in the counter
//     bcd_sanitize : maps an arbitrary nibble onto a legal digit (>9 -> 0)
// ---------------------------------------------------------------------------
package bcd_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t        BCD_MAX    = 4'd9;
  localparam int unsigned NUM_DIGITS = 4;

  // Nibbles that are not valid BCD are loaded as zero so the digit
  // registers can never hold an illegal code.
  function automatic bcd_t bcd_sanitize(input logic [3:0] nib);
    return (nib > BCD_MAX) ? '0 : nib;
  endfunction

endpackage : bcd_pkg

// File: rtl/bcd_digit.sv
// ---------------------------------------------------------------------------
// bcd_digit
//   Purely combinational next-value logic for a single BCD decade.
//   When carry_i is set the digit moves one step in the direction given by
//   up_i, wrapping 9->0 (up) or 0->9 (down) and raising carry_o on the wrap.
//   When carry_i is clear the digit passes through unchanged.
//
//   Ports
//     digit_i : current digit value (0..9)
//     up_i    : 1 = increment, 0 = decrement
//     carry_i : carry (up) / borrow (down) from the next lower decade
//     next_o  : digit value after this step
//     carry_o : carry / borrow into the next higher decade
// ---------------------------------------------------------------------------
module bcd_digit
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       up_i,
  input  logic       carry_i,
  output logic [3:0] next_o,
  output logic       carry_o
);

  always_comb begin
    next_o  = digit_i;
    carry_o = 1'b0;
    if (carry_i) begin
      if (up_i) begin
        if (digit_i >= BCD_MAX) begin
          next_o  = '0;
          carry_o = 1'b1;
        end else begin
          next_o  = digit_i + 4'd1;
        end
      end else begin
        if (digit_i == '0) begin
          next_o  = BCD_MAX;
          carry_o = 1'b1;
        end else begin
          next_o  = digit_i - 4'd1;
        end
      end
    end
  end

endmodule : bcd_digit

// File: rtl/bcd_counter.sv
// ---------------------------------------------------------------------------
// bcd_counter
//   Four-decade up/down BCD counter advanced by a free-running prescaler.
//   The prescaler counts enabled cycles; every TICK_DIV enabled cycles the
//   BCD value steps by one in the direction given by Up. Tick marks the cycle
//   in which the new value is first visible; Wrap additionally marks a full
//   rollover (9999->0000 up, 0000->9999 down).
//
//   Parameters
//     TICK_DIV : clock cycles per count step (2 .. 2**26)
//
//   Ports
//     Clk      : system clock, rising-edge
//     Reset    : asynchronous active-high reset
//     En       : run enable (level); prescaler advances while high
//     Up       : direction, 1 = up, 0 = down; only sampled on the step cycle
//     Clr      : synchronous clear of count and prescaler
//     Load     : synchronous load of Load_Val (illegal nibbles load as 0)
//     Load_Val : four BCD digits, [3:0] = units
//     Dig0..3  : registered digits, units .. thousands
//     Tick     : one-cycle pulse following every step edge
//     Wrap     : one-cycle pulse following a step that wrapped all digits
//
//   Priority within a cycle: Reset > Clr > Load > step.
// ---------------------------------------------------------------------------
module bcd_counter
  import bcd_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        En,
  input  logic        Up,
  input  logic        Clr,
  input  logic        Load,
  input  logic [15:0] Load_Val,
  output logic [3:0]  Dig0,
  output logic [3:0]  Dig1,
  output logic [3:0]  Dig2,
  output logic [3:0]  Dig3,
  output logic        Tick,
  output logic        Wrap
);

  if ((TICK_DIV < 2) || (TICK_DIV > (1 << 26))) begin : g_bad_tick_div
    $error("bcd_counter: TICK_DIV out of range 2..2**26");
  end

  localparam int unsigned          PW     = $clog2(TICK_DIV);
  localparam logic [PW-1:0]        P_LAST = PW'(TICK_DIV - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [PW-1:0]                  p_q,    p_d;
  bcd_t [NUM_DIGITS-1:0]          dig_q,  dig_d;
  logic                           tick_q, tick_d;
  logic                           wrap_q, wrap_d;

  // -------------------------------------------------------------------------
  // Decade chain: the step enters decade 0 as a forced carry and ripples
  // upward within the same cycle. The carry out of the top decade is the
  // full-rollover indication.
  // -------------------------------------------------------------------------
  bcd_t [NUM_DIGITS-1:0]          dig_step;
  logic [NUM_DIGITS:0]            carry;

  assign carry[0] = 1'b1;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_decade
    bcd_digit u_digit (
      .digit_i (dig_q[gi]),
      .up_i    (Up),
      .carry_i (carry[gi]),
      .next_o  (dig_step[gi]),
      .carry_o (carry[gi+1])
    );
  end

  // Load value with illegal nibbles replaced by zero
  bcd_t [NUM_DIGITS-1:0]          dig_load;

  always_comb begin
    dig_load = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      dig_load[i] = bcd_sanitize(Load_Val[4*i +: 4]);
    end
  end

  logic step;
  assign step = En && (p_q == P_LAST);

  // -------------------------------------------------------------------------
  // Next-state
  // -------------------------------------------------------------------------
  always_comb begin
    p_d    = p_q;
    dig_d  = dig_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (Clr) begin
      p_d   = '0;
      dig_d = '0;
    end else if (Load) begin
      p_d   = '0;
      dig_d = dig_load;
    end else if (step) begin
      p_d    = '0;
      dig_d  = dig_step;
      tick_d = 1'b1;
      wrap_d = carry[NUM_DIGITS];
    end else if (En) begin
      p_d = p_q + PW'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      p_q    <= '0;
      dig_q  <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      p_q    <= p_d;
      dig_q  <= dig_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  assign Dig0 = dig_q[0];
  assign Dig1 = dig_q[1];
  assign Dig2 = dig_q[2];
  assign Dig3 = dig_q[3];
  assign Tick = tick_q;
  assign Wrap = wrap_q;

  // -------------------------------------------------------------------------
  // Invariants
  // -------------------------------------------------------------------------
  a_digits_legal : assert property (@(posedge Clk) disable iff (Reset)
    (Dig0 <= BCD_MAX) && (Dig1 <= BCD_MAX) && (Dig2 <= BCD_MAX) && (Dig3 <= BCD_MAX));

  a_wrap_with_tick : assert property (@(posedge Clk) disable iff (Reset)
    Wrap |-> Tick);

  a_prescaler_range : assert property (@(posedge Clk) disable iff (Reset)
    p_q <= P_LAST);

endmodule : bcd_counter

// File: tb/tb_bcd_counter.sv
module tb_bcd_counter;

  localparam int unsigned TD = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        En, Up, Clr, Load;
  logic [15:0] Load_Val;
  logic [3:0]  Dig0, Dig1, Dig2, Dig3;
  logic        Tick, Wrap;

  always #5 Clk = ~Clk;

  bcd_counter #(.TICK_DIV(TD)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .En       (En),
    .Up       (Up),
    .Clr      (Clr),
    .Load     (Load),
    .Load_Val (Load_Val),
    .Dig0     (Dig0),
    .Dig1     (Dig1),
    .Dig2     (Dig2),
    .Dig3     (Dig3),
    .Tick     (Tick),
    .Wrap     (Wrap)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: count held as a plain integer 0..9999
  int mval;
  int mp;
  bit mtick;
  bit mwrap;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int from_load(input logic [15:0] lv);
    int v;
    int w;
    logic [3:0] n;
    v = 0;
    w = 1;
    for (int i = 0; i < 4; i++) begin
      n = lv[4*i +: 4];
      if (n > 4'd9) n = 4'd0;
      v += int'(n) * w;
      w *= 10;
    end
    return v;
  endfunction

  task automatic model_reset();
    mval  = 0;
    mp    = 0;
    mtick = 1'b0;
    mwrap = 1'b0;
  endtask

  task automatic model_edge();
    mtick = 1'b0;
    mwrap = 1'b0;
    if (Clr) begin
      mval = 0;
      mp   = 0;
    end else if (Load) begin
      mval = from_load(Load_Val);
      mp   = 0;
    end else if (En) begin
      if (mp == TD - 1) begin
        mp    = 0;
        mtick = 1'b1;
        if (Up) begin
          mwrap = (mval == 9999);
          mval  = (mval + 1) % 10000;
        end else begin
          mwrap = (mval == 0);
          mval  = (mval + 9999) % 10000;
        end
      end else begin
        mp++;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_dig"},  {Dig3, Dig2, Dig1, Dig0}, to_bcd(mval));
    check({tag, "_tick"}, Tick, mtick);
    check({tag, "_wrap"}, Wrap, mwrap);
  endtask

  task automatic cycle();
    @(posedge Clk);
    if (Reset) model_reset();
    else       model_edge();
    #1;
    compare_all("mdl");
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic async_reset();
    Reset = 1'b1;
    #1;
    model_reset();
    check("areset_dig", {Dig3, Dig2, Dig1, Dig0}, 16'h0000);
    compare_all("areset");
    cycle();
    Reset = 1'b0;
  endtask

  task automatic cycles_to_tick(input int limit, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!Tick && n < limit);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int r;
    Reset = 1'b1; En = 1'b0; Up = 1'b1; Clr = 1'b0; Load = 1'b0; Load_Val = '0;
    #1;
    model_reset();
    compare_all("rst");
    cycle();
    Reset = 1'b0;

    // Free run up: step every TD cycles
    En = 1'b1; Up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      check("run_tick", Tick, (i % 4 == 0));
      check("run_wrap", Wrap, 1'b0);
    end
    check("run_d0", Dig0, 4'd3);

    // Carry ripple 0999 -> 1000
    Load = 1'b1; Load_Val = 16'h0999;
    cycle();
    Load = 1'b0;
    check("ld0999", {Dig3, Dig2, Dig1, Dig0}, 16'h0999);
    check("ld_tick", Tick, 1'b0);
    repeat (4) cycle();
    check("ripple", {Dig3, Dig2, Dig1, Dig0}, 16'h1000);
    check("ripple_tick", Tick, 1'b1);
    check("ripple_wrap", Wrap, 1'b0);

    // Full wrap both directions
    Load = 1'b1; Load_Val = 16'h9999;
    cycle();
    Load = 1'b0;
    repeat (4) cycle();
    check("wrap_up", {Dig3, Dig2, Dig1, Dig0}, 16'h0000);
    check("wrap_up_w", Wrap, 1'b1);
    Up = 1'b0;
    repeat (4) cycle();
    check("wrap_dn", {Dig3, Dig2, Dig1, Dig0}, 16'h9999);
    check("wrap_dn_w", Wrap, 1'b1);
    check("wrap_dn_t", Tick, 1'b1);

    // Illegal nibbles, then Clr+Load on what would be the step cycle
    Up = 1'b1;
    Load = 1'b1; Load_Val = 16'hA3F5;
    cycle();
    Load = 1'b0;
    check("ld_sanit", {Dig3, Dig2, Dig1, Dig0}, 16'h0305);
    repeat (3) cycle();
    Clr = 1'b1; Load = 1'b1; Load_Val = 16'h1234;
    cycle();
    Clr = 1'b0; Load = 1'b0;
    check("clr_dig", {Dig3, Dig2, Dig1, Dig0}, 16'h0000);
    check("clr_tick", Tick, 1'b0);

    // Pause at P=2 for 5 cycles: step lands 5 cycles late
    repeat (2) cycle();
    En = 1'b0;
    repeat (5) cycle();
    En = 1'b1;
    cycles_to_tick(20, n);
    check("pause_delay", n, 2);
    check("pause_dig", {Dig3, Dig2, Dig1, Dig0}, 16'h0001);

    // Reset while Tick is high, then reset mid-interval
    async_reset();
    repeat (2) cycle();
    async_reset();
    cycles_to_tick(20, n);
    check("post_rst_delay", n, 4);
    check("post_rst_dig", {Dig3, Dig2, Dig1, Dig0}, 16'h0001);

    // Randomized traffic against the model
    for (int it = 0; it < 4000; it++) begin
      r = $urandom_range(0, 199);
      if (r == 0) begin
        async_reset();
      end else begin
        En   = ($urandom_range(0, 9) != 0);
        Up   = $urandom_range(0, 1);
        Clr  = (r < 3);
        Load = (r >= 3 && r < 8);
        case ($urandom_range(0, 5))
          0:       Load_Val = 16'h9999;
          1:       Load_Val = 16'h0000;
          2:       Load_Val = 16'h9998;
          default: Load_Val = 16'($urandom);
        endcase
        cycle();
      end
    end
    Clr = 1'b0; Load = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bcd_counter

// File: doc/bcd_counter.md
BCD_COUNTER -- requirements
Module: bcd_counter

Interface
REQ-001 SHALL provide parameter TICK_DIV, default 50_000_000, meaning clock cycles per count step (legal range 2 to 2^26).
REQ-002 SHALL provide port Clk  input  1  meaning system clock; all state updates on its rising edge.
REQ-003 SHALL provide port Reset  input  1  meaning reset, asynchronous and active-high.
REQ-004 SHALL provide port En  input  1  meaning run enable (level); 1 = prescaler advances.
REQ-005 SHALL provide port Up  input  1  meaning count direction; 1 = up, 0 = down; sampled on the step cycle.
REQ-006 SHALL provide port Clr  input  1  meaning synchronous clear of count and prescaler.
REQ-007 SHALL provide port Load  input  1  meaning synchronous load of Load_Val.
REQ-008 SHALL provide port Load_Val  input  16  meaning four BCD digits, [3:0] = units.
REQ-009 SHALL provide ports Dig0, Dig1, Dig2, Dig3  output  4 each  meaning units, tens, hundreds, thousands; each drives one 4-bit hex/7-segment decoder input directly.
REQ-010 SHALL provide port Tick  output  1  meaning one-cycle pulse coincident with every count step.
REQ-011 SHALL provide port Wrap  output  1  meaning one-cycle pulse on 9999->0000 (up) or 0000->9999 (down).

Function
REQ-012 SHALL hold prescaler P in range 0..TICK_DIV-1; P increments on each cycle with En=1 and holds when En=0.
REQ-013 SHALL define a step cycle as a cycle with En=1 and P=TICK_DIV-1; P returns to 0 on that edge.
REQ-014 SHALL, on a step edge, add 1 (Up=1) or subtract 1 (Up=0) from the 4-digit BCD value; new Dig0..3 visible after that edge.
REQ-015 SHALL wrap each digit 9->0 with carry (up) and 0->9 with borrow (down); carry/borrow ripples through all four digits in the same cycle.
REQ-016 SHALL assert Tick for exactly the cycle after each step edge, and Wrap in that same cycle only when all four digits wrapped.
REQ-017 SHALL apply priority Reset > Clr > Load > step within any cycle.
REQ-018 SHALL, on Clr=1, set all digits to 0 and P to 0, and suppress Tick and Wrap for that edge.
REQ-019 SHALL, on Load=1 (Clr=0), load Load_Val into the digits, replacing any nibble >9 with 0; set P to 0; suppress Tick and Wrap.
REQ-020 SHALL keep Dig0..3 registered outputs that always hold values 0..9.
REQ-021 SHALL ignore Up changes except on the step cycle; direction change mid-interval SHALL NOT reset P.
REQ-022 SHALL, with En held 1 from reset release, produce the first step after exactly TICK_DIV rising edges.

Reset
REQ-023 SHALL, while Reset=1, immediately force Dig0..3=0, P=0, Tick=0, Wrap=0, independent of Clk.
REQ-024 SHALL, on Reset assertion mid-interval or mid-wrap, discard partial prescaler progress; counting resumes from 0000 with P=0 after release.

Structure
REQ-025 SHALL place typedef bcd_t (4-bit logic), constants BCD_MAX = 9 and NUM_DIGITS = 4 in shared package bcd_pkg.
REQ-026 SHALL implement one decade as sub-module bcd_digit (inputs: digit, up, carry_in; outputs: next digit, carry_out), instantiated NUM_DIGITS times.
REQ-027 SHALL keep the prescaler and output registers in bcd_counter; bcd_digit SHALL be purely combinational.

Verification (TICK_DIV=4)
REQ-028 SHALL cover: Reset, En=1, Up=1 for 12 cycles -> Dig0 = 1, 2, 3 at cycles 4, 8, 12; Tick high one cycle each time; Wrap=0.
REQ-029 SHALL cover: Load 16'h0999, Up=1, one step -> Dig3..0 = 1,0,0,0; Tick=1; Wrap=0.
REQ-030 SHALL cover: Load 16'h9999, Up=1, one step -> 0000 with Tick=1 and Wrap=1; then Up=0, one step -> 9999 with Wrap=1.
REQ-031 SHALL cover: Load 16'hA3F5 -> digits 0,3,0,5; Clr and Load both asserted -> 0000, no Tick.
REQ-032 SHALL cover: En toggled low for 5 cycles at P=2 -> step delayed exactly 5 cycles; Reset pulse mid-interval -> outputs 0 asynchronously, next step 4 cycles after release.
